// File: rtl/comparador_serial_param_if.sv
// rtl/comparador_serial_param_if.sv - start/busy/done handshake bundle for the serial comparator
interface comparador_serial_param_if #(
  parameter int WIDTH = 8
);
  localparam int BW = $clog2(WIDTH + 1);

  // request side
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // status and result side
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic [BW-1:0]    bits_used;

  // requester: drives operands and start, observes status/result
  modport master (
    output start, dir, a, b,
    input  busy, done, a_gt_b, a_eq_b, a_lt_b, bits_used
  );

  // comparator: consumes the request, produces status/result
  modport slave (
    input  start, dir, a, b,
    output busy, done, a_gt_b, a_eq_b, a_lt_b, bits_used
  );
endinterface

// File: rtl/comparador_serial_param.sv
// rtl/comparador_serial_param.sv - bit-serial magnitude comparator, LSB-first or MSB-first scan
module comparador_serial_param #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  comparador_serial_param_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic          EE_EN  = (EARLY_EXIT != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_GT = 2'b01;
  localparam logic [1:0] REL_LT = 2'b10;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             dir_q;
  logic [KW-1:0]    k;
  logic [1:0]       rel;

  logic             done_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic [BW-1:0]    bits_q;

  logic [KW-1:0]    pos;
  logic             bit_a;
  logic             bit_b;
  logic             differ;
  logic [1:0]       rel_next;
  logic             last_bit;
  logic             early;
  logic             complete;
  logic             accept;

  // Per-edge step of the folded comparison network: pick the bit under scan and update the relation
  always_comb begin
    pos      = dir_q ? (K_LAST - k) : k;
    bit_a    = a_q[pos];
    bit_b    = b_q[pos];
    differ   = bit_a ^ bit_b;
    rel_next = rel;
    if (dir_q) begin
      // MSB first: the first difference decides, later bits cannot change it
      if ((rel == REL_EQ) && differ) begin
        rel_next = bit_a ? REL_GT : REL_LT;
      end
    end else begin
      // LSB first: every difference overrides, so the most significant one wins
      if (differ) begin
        rel_next = bit_a ? REL_GT : REL_LT;
      end
    end
    last_bit = (k == K_LAST);
    early    = dir_q && EE_EN && (rel == REL_EQ) && differ;
    complete = (state == S_RUN) && (last_bit || early);
    accept   = (state == S_IDLE) && bus.start;
  end

  // Sequencer: latch the request on accept, then walk one bit per clock until completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      dir_q <= 1'b0;
      k     <= '0;
      rel   <= REL_EQ;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            dir_q <= bus.dir;
            k     <= '0;
            rel   <= REL_EQ;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          rel <= rel_next;
          if (complete) begin
            state <= S_IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result registers: load only on completion so the display side sees a stable value between results
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b1;
      lt_q   <= 1'b0;
      bits_q <= '0;
    end else begin
      done_q <= complete;
      if (complete) begin
        gt_q   <= (rel_next == REL_GT);
        eq_q   <= (rel_next == REL_EQ);
        lt_q   <= (rel_next == REL_LT);
        bits_q <= BW'(k) + BW'(1);
      end
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = done_q;
  assign bus.a_gt_b    = gt_q;
  assign bus.a_eq_b    = eq_q;
  assign bus.a_lt_b    = lt_q;
  assign bus.bits_used = bits_q;

endmodule

// File: tb/tb_comparador_serial_param.sv
// tb/tb_comparador_serial_param.sv - table-driven bench for comparador_serial_param, both EARLY_EXIT settings
module tb_comparador_serial_param;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  comparador_serial_param_if #(.WIDTH(W)) bus1 ();
  comparador_serial_param_if #(.WIDTH(W)) bus0 ();

  comparador_serial_param #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  comparador_serial_param #(.WIDTH(W), .EARLY_EXIT(0)) dut_ee0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       dir;
    logic [2:0] flags;   // {gt, eq, lt}
    int         lat_ee;  // latency and bits_used with early exit enabled
  } vec_t;

  vec_t vecs[13];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic dir, input logic st);
    bus1.a = a; bus1.b = b; bus1.dir = dir; bus1.start = st;
    bus0.a = a; bus0.b = b; bus0.dir = dir; bus0.start = st;
  endtask

  task automatic set_start(input logic st);
    bus1.start = st;
    bus0.start = st;
  endtask

  function automatic logic [2:0] flags1();
    return {bus1.a_gt_b, bus1.a_eq_b, bus1.a_lt_b};
  endfunction

  function automatic logic [2:0] flags0();
    return {bus0.a_gt_b, bus0.a_eq_b, bus0.a_lt_b};
  endfunction

  // counts posedges after an accept; records first done cycle and number of done pulses per DUT
  task automatic measure(input int budget, output int lat1, output int lat0, output int cnt1, output int cnt0);
    lat1 = 0; lat0 = 0; cnt1 = 0; cnt0 = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (bus1.done) begin
        if (lat1 == 0) lat1 = c;
        cnt1++;
      end
      if (bus0.done) begin
        if (lat0 == 0) lat0 = c;
        cnt0++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int l1, l0, c1, c0;
    @(negedge clk);
    drive(v.a, v.b, v.dir, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check({name, " busy_ee1"}, bus1.busy, 1);
    measure(12, l1, l0, c1, c0);
    check({name, " lat_ee1"}, l1, v.lat_ee);
    check({name, " lat_ee0"}, l0, 8);
    check({name, " pulses_ee1"}, c1, 1);
    check({name, " pulses_ee0"}, c0, 1);
    check({name, " flags_ee1"}, flags1(), v.flags);
    check({name, " flags_ee0"}, flags0(), v.flags);
    check({name, " bits_ee1"}, bus1.bits_used, v.lat_ee);
    check({name, " bits_ee0"}, bus0.bits_used, 8);
  endtask

  initial begin
    int l1, l0, c1, c0;

    vecs[0]  = '{a: 8'h5A, b: 8'h5A, dir: 1'b0, flags: 3'b010, lat_ee: 8};
    vecs[1]  = '{a: 8'h01, b: 8'h02, dir: 1'b0, flags: 3'b001, lat_ee: 8};
    vecs[2]  = '{a: 8'h01, b: 8'h02, dir: 1'b1, flags: 3'b001, lat_ee: 7};
    vecs[3]  = '{a: 8'h80, b: 8'h7F, dir: 1'b1, flags: 3'b100, lat_ee: 1};
    vecs[4]  = '{a: 8'h80, b: 8'h7F, dir: 1'b0, flags: 3'b100, lat_ee: 8};
    vecs[5]  = '{a: 8'h5A, b: 8'h5A, dir: 1'b1, flags: 3'b010, lat_ee: 8};
    vecs[6]  = '{a: 8'h0F, b: 8'hF0, dir: 1'b0, flags: 3'b001, lat_ee: 8};
    vecs[7]  = '{a: 8'h0F, b: 8'hF0, dir: 1'b1, flags: 3'b001, lat_ee: 1};
    vecs[8]  = '{a: 8'hFF, b: 8'hFE, dir: 1'b1, flags: 3'b100, lat_ee: 8};
    vecs[9]  = '{a: 8'h03, b: 8'h01, dir: 1'b0, flags: 3'b100, lat_ee: 8};
    vecs[10] = '{a: 8'h00, b: 8'h00, dir: 1'b0, flags: 3'b010, lat_ee: 8};
    vecs[11] = '{a: 8'hC4, b: 8'hC5, dir: 1'b1, flags: 3'b001, lat_ee: 8};
    vecs[12] = '{a: 8'h10, b: 8'h0F, dir: 1'b1, flags: 3'b100, lat_ee: 4};

    rst = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset busy", bus1.busy, 0);
    check("reset done", bus1.done, 0);
    check("reset flags_ee1", flags1(), 3'b010);
    check("reset flags_ee0", flags0(), 3'b010);
    check("reset bits_used", bus1.bits_used, 0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start pulses while busy are ignored, then a start in the done cycle is accepted
    @(negedge clk);
    drive(8'h5A, 8'h3C, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3 || c == 5) drive(8'h00, 8'hFF, 1'b1, 1'b1);
      else set_start(1'b0);
      @(posedge clk); #1;
      if (c == 5) check("ignore busy", bus1.busy, 1);
      if (c == 7) check("ignore no early done", bus1.done, 0);
    end
    check("ignore done_ee1", bus1.done, 1);
    check("ignore done_ee0", bus0.done, 1);
    check("ignore flags_ee1", flags1(), 3'b100);
    check("ignore flags_ee0", flags0(), 3'b100);
    check("ignore bits", bus1.bits_used, 8);
    drive(8'h22, 8'h24, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check("b2b busy_ee1", bus1.busy, 1);
    check("b2b busy_ee0", bus0.busy, 1);
    measure(12, l1, l0, c1, c0);
    check("b2b lat_ee1", l1, 8);
    check("b2b pulses_ee1", c1, 1);
    check("b2b flags_ee1", flags1(), 3'b001);
    check("b2b flags_ee0", flags0(), 3'b001);

    // reset in the middle of a comparison aborts it without a done
    @(negedge clk);
    drive(8'h0F, 8'hF0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", bus1.busy, 0);
    check("abort done", bus1.done, 0);
    check("abort flags_ee1", flags1(), 3'b010);
    check("abort flags_ee0", flags0(), 3'b010);
    check("abort bits", bus1.bits_used, 0);
    @(negedge clk);
    rst = 1'b0;
    measure(12, l1, l0, c1, c0);
    check("abort no done_ee1", c1, 0);
    check("abort no done_ee0", c0, 0);
    run_vec(vecs[12], "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
